// File: rtl/cmd_sequencer_pkg.sv
// Shared command codes, field widths and queue payload layout for the command sequencer.
// The codes match the engine's command set (idle, advance, read-cell, seed).
package cmd_sequencer_pkg;

  localparam int CMD_W     = 3;
  localparam int ARG_W     = 32;
  localparam int PAYLOAD_W = CMD_W + ARG_W;

  localparam logic [CMD_W-1:0] CMD_IDLE      = 3'd0;
  localparam logic [CMD_W-1:0] CMD_ADVANCE   = 3'd1;
  localparam logic [CMD_W-1:0] CMD_READ_CELL = 3'd2;
  localparam logic [CMD_W-1:0] CMD_SEED      = 3'd3;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [ARG_W-1:0] arg0;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Per-source command queue: first-word-fall-through, power-of-two depth.
// A write and a pop in the same cycle are both honoured, even when full.
module cmd_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Buffers button/host commands, arbitrates them round-robin and issues them to the engine,
// expanding multi-step advances. Define CMD_SEQ_STATS_EN to enable drop/step counters.
module cmd_sequencer
  import cmd_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] src0_cmd,
  input  logic [ARG_W-1:0] src0_arg0,
  input  logic             src0_valid,
  input  logic [CMD_W-1:0] src1_cmd,
  input  logic [ARG_W-1:0] src1_arg0,
  input  logic             src1_valid,
  output logic             src1_ready,
  output logic [CMD_W-1:0] eng_cmd,
  output logic [ARG_W-1:0] eng_arg0,
  output logic             eng_valid,
  input  logic             eng_ready,
  input  logic             eng_done,
  output logic             busy,
  output logic [15:0]      drop_count,
  output logic [31:0]      step_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             last_grant, last_grant_next;
  logic             adv_active, adv_active_next;
  logic             abort_pend, abort_pend_next;
  logic [ARG_W-1:0] remaining, remaining_next;
  logic [CMD_W-1:0] eng_cmd_next;
  logic [ARG_W-1:0] eng_arg0_next;
  logic             eng_valid_next;

  logic full0, empty0, full1, empty1;
  logic pop0, pop1, wr0, wr1;
  logic abort0, abort1;
  logic grant;
  cmd_t head0, head1, head;

  // An IDLE arriving during a multi-step advance is an abort: consumed, never queued.
  assign src1_ready = !full1 && !reset;
  assign abort0     = src0_valid && (src0_cmd == CMD_IDLE) && adv_active;
  assign abort1     = src1_valid && src1_ready && (src1_cmd == CMD_IDLE) && adv_active;
  assign wr0        = src0_valid && !full0 && !abort0;
  assign wr1        = src1_valid && src1_ready && !abort1;
  assign busy       = (state != S_IDLE) || !empty0 || !empty1;

  cmd_fifo #(.WIDTH(PAYLOAD_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .reset(reset), .wr_en(wr0), .wr_data({src0_cmd, src0_arg0}),
    .rd_en(pop0), .rd_data(head0), .full(full0), .empty(empty0)
  );

  cmd_fifo #(.WIDTH(PAYLOAD_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset), .wr_en(wr1), .wr_data({src1_cmd, src1_arg0}),
    .rd_en(pop1), .rd_data(head1), .full(full1), .empty(empty1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      adv_active <= 1'b0;
      abort_pend <= 1'b0;
      remaining  <= '0;
      eng_cmd    <= '0;
      eng_arg0   <= '0;
      eng_valid  <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      adv_active <= adv_active_next;
      abort_pend <= abort_pend_next;
      remaining  <= remaining_next;
      eng_cmd    <= eng_cmd_next;
      eng_arg0   <= eng_arg0_next;
      eng_valid  <= eng_valid_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    adv_active_next = adv_active;
    abort_pend_next = abort_pend || abort0 || abort1;
    remaining_next  = remaining;
    eng_cmd_next    = eng_cmd;
    eng_arg0_next   = eng_arg0;
    eng_valid_next  = eng_valid;
    pop0            = 1'b0;
    pop1            = 1'b0;
    grant           = 1'b0;
    head            = head0;

    case (state)
      S_IDLE: begin
        if (!empty0 || !empty1) begin
          // On a tie, the source not granted last time wins.
          if (!empty0 && !empty1) grant = !last_grant;
          else                    grant = empty0;
          head            = grant ? head1 : head0;
          pop0            = !grant;
          pop1            = grant;
          last_grant_next = grant;
          if (head.cmd == CMD_ADVANCE) begin
            if (head.arg0 != 32'd0) begin
              remaining_next  = head.arg0;
              adv_active_next = 1'b1;
              state_next      = S_ISSUE;
              eng_valid_next  = 1'b1;
              eng_cmd_next    = CMD_ADVANCE;
              eng_arg0_next   = 32'd1;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            state_next     = S_ISSUE;
            eng_valid_next = 1'b1;
            eng_cmd_next   = head.cmd;
            eng_arg0_next  = head.arg0;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (eng_ready) begin
          state_next     = S_WAIT;
          eng_valid_next = 1'b0;
        end else begin
          eng_valid_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          if (adv_active) remaining_next = remaining - 32'd1;
          else            remaining_next = remaining;
          // A pending abort only suppresses the steps after the one just finished.
          if (adv_active && (remaining > 32'd1) && !abort_pend) begin
            state_next     = S_ISSUE;
            eng_valid_next = 1'b1;
          end else begin
            adv_active_next = 1'b0;
            abort_pend_next = 1'b0;
            remaining_next  = '0;
            state_next      = S_IDLE;
          end
        end else begin
          state_next = S_WAIT;
        end
      end
      default: begin
        state_next     = S_IDLE;
        eng_valid_next = 1'b0;
      end
    endcase
  end

`ifdef CMD_SEQ_STATS_EN
  logic [15:0] drops;
  logic [31:0] steps;
  logic        drop_evt;
  logic        step_evt;

  assign drop_evt = src0_valid && full0 && !abort0;
  assign step_evt = (state == S_WAIT) && eng_done && adv_active;

  // Drop counter saturates; step counter wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      drops <= 16'd0;
      steps <= 32'd0;
    end else begin
      if (drop_evt && (drops != 16'hFFFF)) drops <= drops + 16'd1;
      if (step_evt) steps <= steps + 32'd1;
    end
  end

  assign drop_count = drops;
  assign step_count = steps;
`else
  assign drop_count = 16'd0;
  assign step_count = 32'd0;
`endif

endmodule
